// File: rtl/vmicro16_bram_ctl.sv
// Single-port synchronous block RAM with a valid/ready request port, fixed-latency
// in-order responses, selectable write mode and a post-reset clear sequencer.
module vmicro16_bram_ctl #(
  parameter int unsigned MEM_WIDTH      = 16,
  parameter int unsigned MEM_DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH     = $clog2(MEM_DEPTH),
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned WRITE_MODE     = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [MEM_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  output logic [MEM_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned AW1   = ADDR_WIDTH + 1;
  localparam int unsigned LAST  = READ_LATENCY - 1;
  localparam bit          WM_WF = (WRITE_MODE == 0);
  localparam bit          WM_NC = (WRITE_MODE == 2);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];

  logic                  accept_c;
  logic                  in_range_c;
  logic                  hold_c;
  logic [MEM_WIDTH-1:0]  s0_data_c;

  logic                  v_q [READ_LATENCY];
  logic                  e_q [READ_LATENCY];
  logic                  h_q [READ_LATENCY];
  logic [MEM_WIDTH-1:0]  d_q [READ_LATENCY];

  // Clear sequencer: one zeroed cell per cycle, then run forever
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
        state_d   = ST_RUN;
        clr_cnt_d = '0;
      end
    end
    ready_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= CLEAR_ON_RESET;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign accept_c   = req_valid & ready_q;
  assign in_range_c = {1'b0, req_addr} < AW1'(MEM_DEPTH);
  assign hold_c     = req_we & WM_NC;

  // Stage-1 data: array contents (old value on READ_FIRST), or the new word on WRITE_FIRST
  always_comb begin
    s0_data_c = in_range_c ? mem[req_addr] : '0;
    if (req_we && WM_WF) s0_data_c = in_range_c ? req_wdata : '0;
  end

  // Array is left untouched while reset is held
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == ST_CLEAR) mem[clr_cnt_q] <= '0;
      else if (accept_c && req_we && in_range_c) mem[req_addr] <= req_wdata;
    end
  end

  // Response pipe; the last data stage skips NO_CHANGE writes so the old word is re-presented
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < int'(READ_LATENCY); k++) begin
        v_q[k] <= 1'b0;
        e_q[k] <= 1'b0;
        h_q[k] <= 1'b0;
        d_q[k] <= '0;
      end
    end else begin
      v_q[0] <= accept_c;
      e_q[0] <= accept_c & ~in_range_c;
      h_q[0] <= accept_c & hold_c;
      if (accept_c && !(LAST == 0 && hold_c)) d_q[0] <= s0_data_c;
      for (int k = 1; k < int'(READ_LATENCY); k++) begin
        v_q[k] <= v_q[k-1];
        e_q[k] <= e_q[k-1];
        h_q[k] <= h_q[k-1];
        if (v_q[k-1] && !(k == int'(LAST) && h_q[k-1])) d_q[k] <= d_q[k-1];
      end
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = v_q[LAST];
  assign rsp_err   = e_q[LAST];
  assign rsp_rdata = d_q[LAST];

endmodule

// File: tb/tb_vmicro16_bram_ctl.sv
// Directed bench for vmicro16_bram_ctl: three instances cover the latency,
// write-mode, depth and clear-on-reset combinations.
module tb_vmicro16_bram_ctl;

  typedef struct {
    int          u;
    int          t;
    logic        err;
    logic [15:0] d;
  } rsp_t;

  logic        clk;
  logic        rst_n [3];
  logic        vld   [3];
  logic        rdy   [3];
  logic        we    [3];
  logic [7:0]  addr  [3];
  logic [15:0] wdat  [3];
  logic        rv    [3];
  logic [15:0] rdat  [3];
  logic        re    [3];
  logic        bsy   [3];

  int   cyc = 0;
  int   nvec = 0;
  int   nmis = 0;
  int   stray_err = 0;
  rsp_t rsps[$];

  // u0: depth 256, latency 1, WRITE_FIRST
  vmicro16_bram_ctl #(.MEM_WIDTH(16), .MEM_DEPTH(256), .READ_LATENCY(1),
                      .WRITE_MODE(0), .CLEAR_ON_RESET(1'b1)) u0 (
    .clk(clk), .reset(rst_n[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_we(we[0]), .req_addr(addr[0]), .req_wdata(wdat[0]),
    .rsp_valid(rv[0]), .rsp_rdata(rdat[0]), .rsp_err(re[0]), .busy(bsy[0]));

  // u1: depth 256, latency 3, READ_FIRST
  vmicro16_bram_ctl #(.MEM_WIDTH(16), .MEM_DEPTH(256), .READ_LATENCY(3),
                      .WRITE_MODE(1), .CLEAR_ON_RESET(1'b1)) u1 (
    .clk(clk), .reset(rst_n[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_we(we[1]), .req_addr(addr[1]), .req_wdata(wdat[1]),
    .rsp_valid(rv[1]), .rsp_rdata(rdat[1]), .rsp_err(re[1]), .busy(bsy[1]));

  // u2: depth 200, latency 4, NO_CHANGE
  vmicro16_bram_ctl #(.MEM_WIDTH(16), .MEM_DEPTH(200), .READ_LATENCY(4),
                      .WRITE_MODE(2), .CLEAR_ON_RESET(1'b1)) u2 (
    .clk(clk), .reset(rst_n[2]), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_we(we[2]), .req_addr(addr[2]), .req_wdata(wdat[2]),
    .rsp_valid(rv[2]), .rsp_rdata(rdat[2]), .rsp_err(re[2]), .busy(bsy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Response log stamped with the cycle count seen at the negedge
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (rv[u]) rsps.push_back('{u: u, t: cyc, err: re[u], d: rdat[u]});
      if (re[u] && !rv[u]) stray_err++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds the request for one cycle
  task automatic drive(input int u, input logic w, input int a, input int d);
    vld[u]  = 1'b1;
    we[u]   = w;
    addr[u] = 8'(a);
    wdat[u] = 16'(d);
    @(negedge clk);
  endtask

  task automatic idle(input int u);
    vld[u] = 1'b0;
    we[u]  = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_rdy(input int u);
    int n = 0;
    while (!rdy[u] && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("ready_u%0d", u), 32'(rdy[u]), 1);
  endtask

  task automatic busy_len(input int u, output int n);
    n = 0;
    while (bsy[u] && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic rsp_t rsp_at(input int i);
    rsp_t r;
    r = '{u: -1, t: -1, err: 1'bx, d: 16'hxxxx};
    if (i < rsps.size()) r = rsps[i];
    return r;
  endfunction

  initial begin
    int   n;
    int   bad;
    int   n0;
    rsp_t r;

    for (int u = 0; u < 3; u++) begin
      rst_n[u] = 1'b0;
      vld[u]   = 1'b0;
      we[u]    = 1'b0;
      addr[u]  = '0;
      wdat[u]  = '0;
    end
    repeat (2) @(negedge clk);

    check("rst_ready", 32'(rdy[0]), 0);
    check("rst_busy",  32'(bsy[0]), 1);
    check("rst_valid", 32'(rv[0]), 0);
    check("rst_rdata", 32'(rdat[0]), 0);
    check("rst_err",   32'(re[0]), 0);
    for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;
    busy_len(2, n);
    check("clear_len_200", 32'(n), 200);

    // Clear: fill with FFFF, pulse reset, expect 256 busy cycles and an all-zero array
    wait_rdy(0);
    for (int a = 0; a < 256; a++) drive(0, 1'b1, a, 'hFFFF);
    idle(0);
    settle();
    rsps.delete();
    drive(0, 1'b0, 0, 0);
    drive(0, 1'b0, 255, 0);
    idle(0);
    settle();
    check("fill_rd0",   32'(rsp_at(0).d), 'hFFFF);
    check("fill_rd255", 32'(rsp_at(1).d), 'hFFFF);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    check("pulse_ready", 32'(rdy[0]), 0);
    busy_len(0, n);
    check("clear_len_256", 32'(n), 256);
    check("ready_after_clear", 32'(rdy[0]), 1);
    rsps.delete();
    for (int a = 0; a < 256; a++) drive(0, 1'b0, a, 'h5A5A);
    idle(0);
    settle();
    check("clear_scan_cnt", 32'(rsps.size()), 256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (rsp_at(i).d !== 16'h0 || rsp_at(i).err !== 1'b0) bad++;
    check("clear_scan_bad", 32'(bad), 0);

    // Back-to-back reads of 8*i at 0..7, one pulse per cycle
    for (int i = 0; i < 8; i++) drive(0, 1'b1, i, 8 * i);
    idle(0);
    settle();
    rsps.delete();
    n0 = cyc;
    for (int i = 0; i < 8; i++) drive(0, 1'b0, i, 0);
    idle(0);
    settle();
    check("b2b_cnt", 32'(rsps.size()), 8);
    for (int i = 0; i < 8; i++) begin
      r = rsp_at(i);
      check($sformatf("b2b_data%0d", i), 32'(r.d), 32'(8 * i));
      check($sformatf("b2b_time%0d", i), 32'(r.t - n0), 32'(i + 1));
    end
    check("rdata_held", 32'(rdat[0]), 56);

    // WRITE_FIRST returns the new word
    rsps.delete();
    drive(0, 1'b1, 5, 'h1111);
    drive(0, 1'b1, 5, 'h2222);
    drive(0, 1'b0, 5, 0);
    idle(0);
    settle();
    check("wf_first",  32'(rsp_at(0).d), 'h1111);
    check("wf_second", 32'(rsp_at(1).d), 'h2222);
    check("wf_read",   32'(rsp_at(2).d), 'h2222);

    // Latency 3: write BEEF then read on the next cycle (READ_FIRST instance)
    wait_rdy(1);
    rsps.delete();
    drive(1, 1'b1, 'h10, 'hBEEF);
    n0 = cyc;
    drive(1, 1'b0, 'h10, 0);
    idle(1);
    settle();
    check("lat_cnt",    32'(rsps.size()), 2);
    check("rf_wr_old",  32'(rsp_at(0).d), 0);
    check("lat_rdata",  32'(rsp_at(1).d), 'hBEEF);
    check("lat_cycles", 32'(rsp_at(1).t - n0), 3);

    // READ_FIRST returns the old cell contents
    rsps.delete();
    drive(1, 1'b1, 5, 'h1111);
    drive(1, 1'b1, 5, 'h2222);
    drive(1, 1'b0, 5, 0);
    idle(1);
    settle();
    check("rf_second", 32'(rsp_at(1).d), 'h1111);
    check("rf_raw",    32'(rsp_at(2).d), 'h2222);

    // Range on depth 200 (NO_CHANGE, latency 4)
    wait_rdy(2);
    rsps.delete();
    drive(2, 1'b1, 199, 'h1234);
    drive(2, 1'b0, 199, 0);
    drive(2, 1'b1, 200, 'hAAAA);
    drive(2, 1'b0, 200, 0);
    idle(2);
    settle();
    check("rng_cnt",      32'(rsps.size()), 4);
    check("nc_wr_data",   32'(rsp_at(0).d), 0);
    check("rng_rd199",    32'(rsp_at(1).d), 'h1234);
    check("rng_rd199err", 32'(rsp_at(1).err), 0);
    check("rng_wr_err",   32'(rsp_at(2).err), 1);
    check("rng_wr_data",  32'(rsp_at(2).d), 'h1234);
    check("rng_rd_err",   32'(rsp_at(3).err), 1);
    check("rng_rd_data",  32'(rsp_at(3).d), 0);
    rsps.delete();
    for (int a = 0; a < 200; a++) drive(2, 1'b0, a, 0);
    idle(2);
    settle();
    check("rng_scan_cnt", 32'(rsps.size()), 200);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      r = rsp_at(i);
      if (r.d !== ((i == 199) ? 16'h1234 : 16'h0) || r.err !== 1'b0) bad++;
    end
    check("rng_scan_bad", 32'(bad), 0);

    // NO_CHANGE re-presents the previous response word
    rsps.delete();
    drive(2, 1'b1, 5, 'h1111);
    drive(2, 1'b0, 5, 0);
    drive(2, 1'b1, 5, 'h2222);
    drive(2, 1'b0, 5, 0);
    idle(2);
    settle();
    check("nc_rd1",  32'(rsp_at(1).d), 'h1111);
    check("nc_wr2",  32'(rsp_at(2).d), 'h1111);
    check("nc_raw",  32'(rsp_at(3).d), 'h2222);

    // Reset while three reads are in flight: no pulse may follow
    rsps.delete();
    drive(2, 1'b0, 5, 0);
    drive(2, 1'b0, 199, 0);
    drive(2, 1'b0, 0, 0);
    idle(2);
    rst_n[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    check("mid_rst_ready", 32'(rdy[2]), 0);
    busy_len(2, n);
    check("mid_clear_len", 32'(n), 200);
    settle();
    check("mid_no_pulse", 32'(rsps.size()), 0);
    rsps.delete();
    drive(2, 1'b0, 5, 0);
    drive(2, 1'b1, 7, 'h4321);
    n0 = cyc;
    drive(2, 1'b0, 7, 0);
    idle(2);
    settle();
    check("post_cleared",  32'(rsp_at(0).d), 0);
    check("post_rdata",    32'(rsp_at(2).d), 'h4321);
    check("post_latency",  32'(rsp_at(2).t - n0), 4);

    check("stray_err", 32'(stray_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
